byte_data_memory: RTL and testbench
===================================

# byte_data_memory

- Parametrised data memory with byte/halfword/word access, sign/zero-extended loads and byte-enabled stores.
- Uses a valid/ready request and response handshake with one outstanding transaction and registered read data.
- Flags misaligned and out-of-range accesses.
- Sits between the core's MEM stage / load-store unit and on-chip RAM, replacing the fixed word-only, combinational-read data memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4
- ADDR_W, 32: request address width; byte address

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as fault
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  access was misaligned, out of range, or had an illegal size

## Operation
- FSM states:
  - IDLE: no response pending.
  - RESP: response held on rsp_*.
- req_ready = (state == IDLE) || rsp_ready. A new request is accepted in the same cycle the previous response is consumed, giving back-to-back throughput of 1 per cycle.
- On accept:
  - evaluate the fault, perform the store, capture the load result into the response registers;
  - state ← RESP.
- RESP with rsp_ready and no new accept → IDLE.
- Fault conditions:
  - size 11;
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - addr[ADDR_W-1:2] ≥ DEPTH_WORDS.
- Faulted store: memory unchanged. Faulted load: rsp_rdata = 0. In both cases rsp_fault = 1.
- Store lanes:
  - byte: wdata[7:0] replicated, strobe bit addr[1:0];
  - half: wdata[15:0] replicated, strobe 0011 or 1100 per addr[1];
  - word: strobe 1111.
  - Unstrobed bytes are preserved.
- Load: select the lane by addr[1:0]/addr[1], then extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Store response: rsp_valid with rsp_rdata = 0, rsp_fault as evaluated.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (async assert, sync-safe deassert): state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0, req_ready = 1. No memory write occurs while rst_n = 0.
- Load latency: accept at edge N → rsp_valid high after edge N, data stable until consumed.
- rsp_rdata/rsp_fault hold steady while rsp_valid && !rsp_ready.
- Store takes effect at the accept edge. A load accepted on the next edge returns the new data; store-to-load forwarding is not needed.
- Reset mid-transaction: the pending response is dropped. A store accepted on the same edge that reset asserts is not guaranteed.

## Structure
- Package data_mem_pkg holds:
  - enum mem_size_e {SZ_BYTE, SZ_HALF, SZ_WORD};
  - function load_extend(word, addr_lo, size, unsigned);
  - function store_strobe(addr_lo, size).
- Sub-module data_mem_array: DEPTH_WORDS × 32 RAM with 4-bit byte write enable and synchronous read port, inferable as block RAM.
- The top holds the FSM, fault check, lane steering and response registers.

## Test plan
- Store word 0xDEADBEEF @0x10, then load word @0x10 → rsp_rdata 0xDEADBEEF, fault 0, one-cycle latency.
- Store byte 0x80 @0x13 over 0x11223344, then:
  - load word @0x10 → 0x80223344;
  - load byte signed @0x13 → 0xFFFFFF80;
  - load byte unsigned @0x13 → 0x00000080.
- Store half 0xBEEF @0x22 over 0, then:
  - load half signed @0x22 → 0xFFFFBEEF;
  - load half unsigned @0x20 → 0x00000000.
- Faults, each → rsp_fault 1 and rsp_rdata 0, with the target word unchanged:
  - load word @0x11;
  - store half @0x21;
  - load @ DEPTH_WORDS*4.
- Backpressure: hold rsp_ready = 0 for 3 cycles with req_valid high → req_ready 0 and rsp held constant. Releasing rsp_ready accepts the next request that same cycle, then sustains 1 transaction per cycle.
- Assert rst_n low while in RESP → rsp_valid 0 immediately (async) and req_ready 1 after release.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and lane helpers for the byte-addressable data memory.
// Covers the access-size encoding, the response FSM states and the load/store lane logic.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  // Byte write strobe for an aligned access; an illegal size strobes nothing.
  function automatic logic [3:0] store_strobe(input logic [1:0] addr_lo, input mem_size_e size);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] addr_lo,
                                              input mem_size_e size, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return {{24{~is_unsigned & b[7]}}, b};
      SZ_HALF: return {{16{~is_unsigned & h[15]}}, h};
      SZ_WORD: return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Written so that synthesis can map it onto block RAM.
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // NOTE: no reset on the array or its read register; a reset would stop block-RAM inference.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/byte_data_memory.sv
// Data memory front end: valid/ready request and response handshake, fault check,
// store lane steering and load extension around a byte-enabled RAM.
module byte_data_memory
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q;
  logic        fault_q, load_q, uns_q;
  logic [1:0]  addr_lo_q, size_q;

  logic        accept, fault;
  logic [31:0] wdata_lane, ram_rdata;
  logic [3:0]  ram_we;
  logic        ram_re;

  assign req_ready = (state_q == ST_IDLE) || rsp_ready;
  assign accept    = req_valid && req_ready;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    fault = 1'b0;
    if (req_size == 2'b11)                               fault = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])              fault = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)   fault = 1'b1;
    if ((req_addr >> (AW + 2)) != '0)                    fault = 1'b1;

    wdata_lane = req_wdata;
    case (req_size)
      SZ_BYTE: wdata_lane = {4{req_wdata[7:0]}};
      SZ_HALF: wdata_lane = {2{req_wdata[15:0]}};
      default: wdata_lane = req_wdata;
    endcase
  end

  // Faulted accesses touch nothing; writes are also blocked while reset is held.
  assign ram_we = (accept && req_we && !fault && rst_n)
                ? store_strobe(req_addr[1:0], mem_size_e'(req_size)) : 4'b0000;
  assign ram_re = accept && !req_we && !fault;

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (req_addr[AW+1:2]),
    .wdata_i (wdata_lane),
    .rdata_o (ram_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      fault_q   <= 1'b0;
      load_q    <= 1'b0;
      uns_q     <= 1'b0;
      addr_lo_q <= 2'b00;
      size_q    <= 2'b00;
    end else if (accept) begin
      state_q   <= ST_RESP;
      fault_q   <= fault;
      load_q    <= !req_we && !fault;
      uns_q     <= req_unsigned;
      addr_lo_q <= req_addr[1:0];
      size_q    <= req_size;
    end else if (state_q == ST_RESP && rsp_ready) begin
      state_q   <= ST_IDLE;
    end
  end

  // The RAM read register only changes on accept, so the extended data holds under backpressure.
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_fault = fault_q;
  assign rsp_rdata = (rsp_valid && load_q)
                   ? load_extend(ram_rdata, addr_lo_q, mem_size_e'(size_q), uns_q) : 32'h0;

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory: directed vector table, backpressure and reset
// sequences, then random traffic checked against a byte-array reference model.
module tb_byte_data_memory;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mdl [NBYTES];

  always #5 clk = ~clk;

  byte_data_memory #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: little-endian byte array, fault rules applied to the plain byte address.
  task automatic mdl_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic f);
    int n;
    n  = 1 << size;
    f  = (size == 2'd3) || (addr % n != 0) || (addr / 4 >= DEPTH);
    rd = '0;
    if (!f) begin
      for (int i = 0; i < n; i++) begin
        if (we) mdl[addr + i] = wdata[8*i +: 8];
        else    rd = rd | (32'(mdl[addr + i]) << (8 * i));
      end
      if (!we && !uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8 * n)) - 1);
    end
  endtask

  // One isolated transaction: request, one-cycle response, consume.
  task automatic txn(input string name, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic f);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr;  req_wdata = wdata; rsp_ready = 1'b0;
    check({name, ".req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    f  = rsp_fault;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr;  req_wdata = 32'h0;
  endtask

  initial begin
    logic [31:0] rd, exp_rd;
    logic        f, exp_f;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    // Known contents everywhere so the model and RAM agree
    for (int w = 0; w < DEPTH; w++) begin
      txn("init", 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'h0, rd, f);
      mdl_access(1'b1, 2'd2, 1'b0, 32'(w * 4), 32'h0, exp_rd, exp_f);
    end

    vecs.push_back('{"st_w_10",      1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{"ld_w_10",      1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{"st_w_10b",     1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{"st_b_13",      1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 32'h0,        1'b0});
    vecs.push_back('{"ld_w_10m",     1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h80223344, 1'b0});
    vecs.push_back('{"ld_bs_13",     1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{"ld_bu_13",     1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0});
    vecs.push_back('{"st_w_20",      1'b1, 2'd2, 1'b0, 32'h20, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{"st_h_22",      1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 32'h0,        1'b0});
    vecs.push_back('{"ld_hs_22",     1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        32'hFFFFBEEF, 1'b0});
    vecs.push_back('{"ld_hu_20",     1'b0, 2'd1, 1'b1, 32'h20, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{"ld_w_11_flt",  1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"ld_w_10_keep", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h80223344, 1'b0});
    vecs.push_back('{"st_h_21_flt",  1'b1, 2'd1, 1'b0, 32'h21, 32'h00001234, 32'h0,        1'b1});
    vecs.push_back('{"ld_w_20_keep", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'hBEEF0000, 1'b0});
    vecs.push_back('{"ld_oor_flt",   1'b0, 2'd2, 1'b0, 32'(DEPTH*4), 32'h0,  32'h0,        1'b1});
    vecs.push_back('{"ld_sz3_flt",   1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"st_sz3_flt",   1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1});
    vecs.push_back('{"ld_w_10_end",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h80223344, 1'b0});

    foreach (vecs[i]) begin
      txn(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, f);
      mdl_access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, exp_rd, exp_f);
      check({vecs[i].name, ".rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, ".fault"}, 32'(f), 32'(vecs[i].exp_fault));
    end

    // Backpressure, then back-to-back throughput
    @(negedge clk);
    drive_req(1'b0, 2'd2, 1'b0, 32'h10);
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp.first_valid", 32'(rsp_valid), 32'd1);
    drive_req(1'b0, 2'd2, 1'b0, 32'h20);
    for (int c = 0; c < 3; c++) begin
      check("bp.req_ready", 32'(req_ready), 32'd0);
      check("bp.rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp.rsp_rdata", rsp_rdata, 32'h80223344);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("bp.release_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("b2b.0", rsp_rdata, 32'hBEEF0000);
    drive_req(1'b0, 2'd0, 1'b0, 32'h13);
    @(negedge clk);
    check("b2b.1", rsp_rdata, 32'hFFFFFF80);
    drive_req(1'b0, 2'd2, 1'b0, 32'h10);
    @(negedge clk);
    check("b2b.2", rsp_rdata, 32'h80223344);
    check("b2b.2_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b.drain", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    // Reset while a faulted response is pending; stores during reset must not land
    drive_req(1'b0, 2'd2, 1'b0, 32'h11);
    @(negedge clk);
    check("rstm.pend_fault", 32'(rsp_fault), 32'd1);
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rstm.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstm.rsp_fault", 32'(rsp_fault), 32'd0);
    check("rstm.rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    check("rstm.req_ready", 32'(req_ready), 32'd1);
    check("rstm.idle", 32'(rsp_valid), 32'd0);
    txn("rstm.mem_kept", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, f);
    check("rstm.mem_kept.rdata", rd, 32'h80223344);

    // Random traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      logic        we, uns;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      if (size == 2'd3 && $urandom_range(0, 2) != 0) size = 2'd2;
      addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 7));
      if (size != 2'd0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(3);
      wdata = $urandom;
      txn("rnd", we, size, uns, addr, wdata, rd, f);
      mdl_access(we, size, uns, addr, wdata, exp_rd, exp_f);
      check("rnd.rdata", rd, exp_rd);
      check("rnd.fault", 32'(f), 32'(exp_f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
